// File: rtl/ex_data_req_pkg.sv
// Shared encodings for the EX-stage data request controller.
package ex_data_req_pkg;

  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;

  typedef enum logic [1:0] {
    DreqIdle = 2'd0,
    DreqReq  = 2'd1,
    DreqWait = 2'd2
  } dreq_state_e;

endpackage

// File: rtl/ex_data_req.sv
// EX-stage data-bus request controller: issues one load/store at a time, holds it until
// accepted, and forwards only live load responses to MEM.
module ex_data_req
  import ex_data_req_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_valid,
  input  logic        es_mem_op,
  input  logic        es_is_store,
  input  logic        es_ex,
  input  logic [1:0]  es_size,
  input  logic [31:0] es_addr,
  input  logic [31:0] es_wdata,
  input  logic [3:0]  es_wstrb,
  input  logic        es_fire,
  input  logic        reflush,
  output logic        es_mem_ready_go,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok_bus,
  input  logic [31:0] data_sram_rdata_bus,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  dreq_state_e state_q;
  logic        issued_q;
  logic        discard_q;
  logic        wait_is_load_q;
  logic        hold_wr_q;
  logic [1:0]  hold_size_q;
  logic [31:0] hold_addr_q;
  logic [31:0] hold_wdata_q;
  logic [3:0]  hold_wstrb_q;

  logic issue;
  logic in_req;
  logic own_hs;

  assign in_req = (state_q == DreqReq);
  assign issue  = es_valid & es_mem_op & ~es_ex & ~issued_q & ~reflush & (state_q == DreqIdle);

  assign data_sram_req = issue | in_req;

  // A held request whose instruction was flushed still completes on the bus, but its
  // acceptance must not count as progress for whatever instruction now sits in EX.
  assign own_hs = (issue | (in_req & ~discard_q)) & data_sram_addr_ok;

  always_comb begin
    data_sram_wr    = es_is_store;
    data_sram_size  = es_size;
    data_sram_addr  = es_addr;
    data_sram_wdata = es_wdata;
    data_sram_wstrb = es_wstrb;
    if (in_req) begin
      data_sram_wr    = hold_wr_q;
      data_sram_size  = hold_size_q;
      data_sram_addr  = hold_addr_q;
      data_sram_wdata = hold_wdata_q;
      data_sram_wstrb = hold_wstrb_q;
    end
  end

  assign es_mem_ready_go = ~es_mem_op | es_ex | issued_q | own_hs;

  // A same-cycle flush drops the response even before discard has been registered.
  assign data_sram_data_ok = (state_q == DreqWait) & data_sram_data_ok_bus & wait_is_load_q &
                             ~discard_q & ~reflush;
  assign data_sram_rdata   = data_sram_rdata_bus;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= DreqIdle;
      issued_q       <= 1'b0;
      discard_q      <= 1'b0;
      wait_is_load_q <= 1'b0;
      hold_wr_q      <= 1'b0;
      hold_size_q    <= 2'd0;
      hold_addr_q    <= 32'd0;
      hold_wdata_q   <= 32'd0;
      hold_wstrb_q   <= 4'd0;
    end else begin
      case (state_q)
        DreqIdle: begin
          if (issue) begin
            wait_is_load_q <= ~es_is_store;
            discard_q      <= 1'b0;
            if (data_sram_addr_ok) begin
              state_q <= DreqWait;
            end else begin
              state_q      <= DreqReq;
              hold_wr_q    <= es_is_store;
              hold_size_q  <= es_size;
              hold_addr_q  <= es_addr;
              hold_wdata_q <= es_wdata;
              hold_wstrb_q <= es_wstrb;
            end
          end
        end
        DreqReq: begin
          if (reflush) discard_q <= 1'b1;
          if (data_sram_addr_ok) state_q <= DreqWait;
        end
        DreqWait: begin
          if (reflush) discard_q <= 1'b1;
          if (data_sram_data_ok_bus) state_q <= DreqIdle;
        end
        default: state_q <= DreqIdle;
      endcase
      issued_q <= (issued_q | own_hs) & ~(es_fire | reflush);
    end
  end

  // Responses may only arrive for an accepted transaction.
  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    data_sram_data_ok_bus |-> (state_q == DreqWait));

  a_legal_size: assert property (@(posedge clk) disable iff (!resetn)
    data_sram_req |-> (data_sram_size <= SizeW));

endmodule
